// File: rtl/bnn_ocr_top.sv
// ---------------------------------------------------------------------------
// bnn_ocr_top
// Binary neural network core for IMG x IMG binary digit images:
//   conv3x3 (XNOR-popcount, threshold) -> 2x2 max-pool -> fully connected
//   XNOR-popcount layer -> running argmax -> class 0..NCLASS-1.
//
// Timing: the image is captured at edge 0, one pooled row is produced per
// cycle at edges 1..14, one class score per cycle at edges 15..24, and
// result/data_out_ready update at edge 24.
//
// Ports
//   clk             in   rising-edge clock
//   rst_n           in   asynchronous active-low reset
//   conv1_img_in    in   [IMG*IMG-1:0] x [0:IC-1] image, pixel (r,c) at
//                        bit IMG*IMG-1-(r*IMG+c); 1 = +1, 0 = -1
//   data_in_ready   in   start request level
//   result          out  [3:0] predicted class
//   data_out_ready  out  result valid
//   score_out       out  [9:0] winning popcount (only with BNN_SCORE_OUT_EN)
//
// Configuration macro: BNN_SCORE_OUT_EN adds the score_out port/register.
// ---------------------------------------------------------------------------
module bnn_ocr_top #(
  parameter int IMG     = 30,
  parameter int IC      = 1,
  parameter int OC      = 4,
  parameter int NCLASS  = 10,
  parameter logic [OC*9-1:0] CONV_W = {OC*9{1'b1}},
  parameter int CONV_TH = 5,
  parameter logic [NCLASS*OC*((IMG-2)/2)*((IMG-2)/2)-1:0] FC_W = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IMG*IMG-1:0]   conv1_img_in [0:IC-1],
  input  logic                 data_in_ready,
  output logic [3:0]           result,
  output logic                 data_out_ready
`ifdef BNN_SCORE_OUT_EN
  ,
  output logic [9:0]           score_out
`endif
);

  localparam int CW  = IMG - 2;   // conv output side
  localparam int PW  = CW / 2;    // pooled side
  localparam int PSZ = PW * PW;   // pooled pixels per channel
  localparam int F   = OC * PSZ;  // feature vector length

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_FC, S_DONE} state_e;

  function automatic logic [3:0] popcnt9(input logic [8:0] v);
    logic [3:0] s;
    s = '0;
    for (int k = 0; k < 9; k++) s = s + 4'(v[k]);
    return s;
  endfunction

  function automatic logic [9:0] popcnt_f(input logic [F-1:0] v);
    logic [9:0] s;
    s = '0;
    for (int k = 0; k < F; k++) s = s + 10'(v[k]);
    return s;
  endfunction

  state_e               state_q, state_d;
  logic [3:0]           py_q, py_d;
  logic [3:0]           cls_q, cls_d;
  logic [3:0]           best_idx_q, best_idx_d;
  logic [9:0]           best_score_q, best_score_d;
  logic [3:0]           result_q, result_d;
  logic                 dout_q, dout_d;
  logic [IMG*IMG-1:0]   img_q, img_d;
  logic [F-1:0]         feat_q;
  logic                 feat_we;
`ifdef BNN_SCORE_OUT_EN
  logic [9:0]           score_q, score_d;
`endif

  // -------------------------------------------------------------------------
  // Convolution window: the four image rows 2*py .. 2*py+3 feed the two conv
  // rows that collapse into pooled row py.
  // -------------------------------------------------------------------------
  logic [IMG-1:0] win_rows [0:3];

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      win_rows[k] = img_q[IMG*IMG-1 - (2*int'(py_q) + k)*IMG -: IMG];
    end
  end

  // conv_bits[(oc*2+dy)*CW + x] = conv output at row 2*py+dy, column x
  logic [OC*2*CW-1:0] conv_bits;
  logic [OC*PW-1:0]   pool_row;

  for (genvar g_oc = 0; g_oc < OC; g_oc++) begin : g_ch
    for (genvar g_dy = 0; g_dy < 2; g_dy++) begin : g_row
      for (genvar g_x = 0; g_x < CW; g_x++) begin : g_col
        logic [8:0] xn;
        for (genvar g_i = 0; g_i < 3; g_i++) begin : g_ki
          for (genvar g_j = 0; g_j < 3; g_j++) begin : g_kj
            // win_rows[...] is MSB-first: column c lives at bit IMG-1-c
            assign xn[g_i*3+g_j] = ~(win_rows[g_dy+g_i][IMG-1-(g_x+g_j)]
                                     ^ CONV_W[g_oc*9+g_i*3+g_j]);
          end
        end
        assign conv_bits[(g_oc*2+g_dy)*CW+g_x] = (int'(popcnt9(xn)) >= CONV_TH);
      end
    end
    for (genvar g_px = 0; g_px < PW; g_px++) begin : g_pool
      assign pool_row[g_oc*PW+g_px] = conv_bits[(g_oc*2)*CW   + 2*g_px]
                                    | conv_bits[(g_oc*2)*CW   + 2*g_px+1]
                                    | conv_bits[(g_oc*2+1)*CW + 2*g_px]
                                    | conv_bits[(g_oc*2+1)*CW + 2*g_px+1];
    end
  end

  // -------------------------------------------------------------------------
  // Fully connected layer: one class per cycle
  // -------------------------------------------------------------------------
  logic [F-1:0] fc_w_arr [0:NCLASS-1];
  logic [F-1:0] fc_w_sel;
  logic [9:0]   fc_score;

  for (genvar g_c = 0; g_c < NCLASS; g_c++) begin : g_fcw
    assign fc_w_arr[g_c] = FC_W[g_c*F +: F];
  end

  assign fc_w_sel = fc_w_arr[cls_q];
  assign fc_score = popcnt_f(~(feat_q ^ fc_w_sel));

  // -------------------------------------------------------------------------
  // Control FSM, next-state and datapath updates
  // -------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    py_d         = py_q;
    cls_d        = cls_q;
    best_idx_d   = best_idx_q;
    best_score_d = best_score_q;
    result_d     = result_q;
    dout_d       = dout_q;
    img_d        = img_q;
    feat_we      = 1'b0;
`ifdef BNN_SCORE_OUT_EN
    score_d      = score_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (data_in_ready) begin
          img_d   = conv1_img_in[0];
          py_d    = '0;
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        feat_we = 1'b1;
        if (py_q == 4'(PW-1)) begin
          cls_d   = '0;
          state_d = S_FC;
        end else begin
          py_d = py_q + 4'd1;
        end
      end
      S_FC: begin
        // Strictly-greater update keeps the lowest index on ties; class 0
        // seeds the running best regardless of the previous run.
        if (cls_q == '0 || fc_score > best_score_q) begin
          best_idx_d   = cls_q;
          best_score_d = fc_score;
        end
        if (cls_q == 4'(NCLASS-1)) begin
          result_d = best_idx_d;
          dout_d   = 1'b1;
          state_d  = S_DONE;
`ifdef BNN_SCORE_OUT_EN
          score_d  = best_score_d;
`endif
        end else begin
          cls_d = cls_q + 4'd1;
        end
      end
      S_DONE: begin
        if (!data_in_ready) begin
          dout_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      py_q         <= '0;
      cls_q        <= '0;
      best_idx_q   <= '0;
      best_score_q <= '0;
      result_q     <= '0;
      dout_q       <= 1'b0;
      img_q        <= '0;
`ifdef BNN_SCORE_OUT_EN
      score_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      py_q         <= py_d;
      cls_q        <= cls_d;
      best_idx_q   <= best_idx_d;
      best_score_q <= best_score_d;
      result_q     <= result_d;
      dout_q       <= dout_d;
      img_q        <= img_d;
`ifdef BNN_SCORE_OUT_EN
      score_q      <= score_d;
`endif
    end
  end

  // Feature store: pooled row py of every channel lands at oc*PSZ + py*PW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      feat_q <= '0;
    end else if (feat_we) begin
      for (int oc = 0; oc < OC; oc++) begin
        feat_q[oc*PSZ + int'(py_q)*PW +: PW] <= pool_row[oc*PW +: PW];
      end
    end
  end

  assign result         = result_q;
  assign data_out_ready = dout_q;
`ifdef BNN_SCORE_OUT_EN
  assign score_out      = score_q;
`endif

endmodule

// File: tb/tb_bnn_ocr_top.sv
// ---------------------------------------------------------------------------
// tb_bnn_ocr_top
// Directed bench for bnn_ocr_top. FC weights: class 7 all ones, others zero,
// so class 7 scores the count of set features and every other class scores
// the count of clear features (ties resolve to class 0).
// ---------------------------------------------------------------------------
module tb_bnn_ocr_top;

  localparam int F = 784;
  localparam logic [10*F-1:0] FCW = {{(2*F){1'b0}}, {F{1'b1}}, {(7*F){1'b0}}};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         din = 1'b0;
  logic [899:0] img_r = '0;
  logic [899:0] img_arr [0:0];
  logic [3:0]   result;
  logic         dout;
`ifdef BNN_SCORE_OUT_EN
  logic [9:0]   score_out;
`endif

  int tests = 0;
  int fails = 0;

  assign img_arr[0] = img_r;

  always #5 clk = ~clk;

  bnn_ocr_top #(.FC_W(FCW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .conv1_img_in   (img_arr),
    .data_in_ready  (din),
    .result         (result),
    .data_out_ready (dout)
`ifdef BNN_SCORE_OUT_EN
    ,
    .score_out      (score_out)
`endif
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("[TB] check %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic logic [899:0] mk_left(input int ncols);
    logic [899:0] v;
    v = '0;
    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 30; c++)
        v[899-(r*30+c)] = (c < ncols);
    return v;
  endfunction

  function automatic logic [899:0] mk_checker();
    logic [899:0] v;
    v = '0;
    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 30; c++)
        v[899-(r*30+c)] = ((r + c) % 2 == 0);
    return v;
  endfunction

  // Full run: capture edge, latency check at edges 23/24, drop start.
  task automatic run(input string tag, input logic [899:0] im, input logic [3:0] exp);
    img_r = im;
    din   = 1'b1;
    @(posedge clk); #1;                       // edge 0: capture
    repeat (23) @(posedge clk);
    #1;
    check({tag, "_dout_e23"}, 16'(dout), 16'd0);
    @(posedge clk); #1;                       // edge 24
    check({tag, "_dout_e24"}, 16'(dout), 16'd1);
    check({tag, "_result"}, 16'(result), 16'(exp));
    din = 1'b0;
    @(posedge clk); #1;
    check({tag, "_dout_fall"}, 16'(dout), 16'd0);
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_result", 16'(result), 16'd0);
    check("rst_dout", 16'(dout), 16'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // All-ones image: every feature set, class 7 scores 784; start held
    img_r = mk_left(30);
    din   = 1'b1;
    @(posedge clk); #1;
    repeat (23) @(posedge clk);
    #1;
    check("ones_dout_e23", 16'(dout), 16'd0);
    @(posedge clk); #1;
    check("ones_dout_e24", 16'(dout), 16'd1);
    check("ones_result", 16'(result), 16'd7);
`ifdef BNN_SCORE_OUT_EN
    check("ones_score", 16'(score_out), 16'd784);
`endif
    repeat (5) @(posedge clk);
    #1;
    check("hold_dout", 16'(dout), 16'd1);
    check("hold_result", 16'(result), 16'd7);
    din = 1'b0;
    @(posedge clk); #1;
    check("drop_dout", 16'(dout), 16'd0);
    check("idle_result_kept", 16'(result), 16'd7);

    // Reset mid-CONV at edge 5 clears outputs immediately
    img_r = '0;
    din   = 1'b1;
    @(posedge clk); #1;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_result", 16'(result), 16'd0);
    check("midrst_dout", 16'(dout), 16'd0);
    din = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("aborted_no_dout", 16'(dout), 16'd0);

    // Directed images
    run("ones2", mk_left(30), 4'd7);
    run("zeros", '0, 4'd0);
    run("checker", mk_checker(), 4'd7);   // windows hold exactly 5 ones on even parity
    run("left15", mk_left(15), 4'd0);     // 392 set vs 392 clear -> tie -> class 0
    run("left16", mk_left(16), 4'd7);     // 448 set features
    run("zeros2", '0, 4'd0);

    // Input changes and start drop mid-run do not disturb the run
    img_r = mk_left(30);
    din   = 1'b1;
    @(posedge clk); #1;                   // edge 0
    repeat (10) @(posedge clk);
    #1;                                   // edge 10
    din   = 1'b0;
    img_r = '0;
    repeat (13) @(posedge clk);
    #1;                                   // edge 23
    check("chg_dout_e23", 16'(dout), 16'd0);
    @(posedge clk); #1;                   // edge 24
    check("chg_dout_e24", 16'(dout), 16'd1);
    check("chg_result", 16'(result), 16'd7);
    @(posedge clk); #1;
    check("chg_done_1cyc", 16'(dout), 16'd0);
    repeat (30) @(posedge clk);
    #1;
    check("chg_no_restart", 16'(dout), 16'd0);
    check("chg_result_kept", 16'(result), 16'd7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
